// File: rtl/cordic_rot.sv
// cordic_rot: iterative rotation-mode CORDIC turning a polar pair (r, phi) into (x, y).
// Quadrant pre-rotation and 1/K gain compensation happen in LOAD, then N micro-rotations.
module cordic_rot #(
  parameter int W = 7,
  parameter int N = 8,
  parameter int G = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic signed [W:0] r_in,
  input  logic signed [W:0] phi_in,
  output logic              busy,
  output logic              done,
  output logic signed [W:0] x,
  output logic signed [W:0] y,
  output logic signed [W:0] eps,
  output logic [1:0]        dbg_state
);

  // Handshake: start is sampled only in IDLE; busy is high from the edge after acceptance
  // through the done cycle; done is a one-cycle pulse coinciding with fresh x/y/eps.
  localparam int IW  = W + 2 + G;
  localparam int ASH = (W < 15) ? 15 - W : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  localparam logic signed [IW-1:0] SAT_HI = IW'((1 << W) - 1);
  localparam logic signed [IW-1:0] SAT_LO = IW'(-(1 << W));
  localparam logic signed [IW-1:0] RND    = IW'((1 << G) >> 1);

  logic [1:0]           state_q, state_d;
  logic [3:0]           i_q, i_d;
  logic signed [W:0]    r_q, r_d, phi_q, phi_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d;
  logic signed [W:0]    z_q, z_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic signed [W:0]    xo_q, xo_d, yo_q, yo_d, eps_q, eps_d;

  logic                 quad;
  logic signed [IW-1:0] r_ext, x_pre, x_gain, x_sh, y_sh;
  logic signed [W:0]    z_pre, at;

  // 16-bit binary-radian arctangents rounded half-up down to W+1 bits.
  function automatic logic signed [W:0] atan_c(input logic [3:0] idx);
    int a;
    case (idx)
      4'd0:    a = 8192;
      4'd1:    a = 4836;
      4'd2:    a = 2555;
      4'd3:    a = 1297;
      4'd4:    a = 651;
      4'd5:    a = 326;
      4'd6:    a = 163;
      4'd7:    a = 81;
      4'd8:    a = 41;
      4'd9:    a = 20;
      default: a = 0;
    endcase
    a = (a + ((1 << ASH) >> 1)) >> ASH;
    return a[W:0];
  endfunction

  function automatic logic signed [W:0] sat_rnd(input logic signed [IW-1:0] v);
    logic signed [IW-1:0] t;
    t = (v + RND) >>> G;
    if (t > SAT_HI)      return SAT_HI[W:0];
    else if (t < SAT_LO) return SAT_LO[W:0];
    else                 return t[W:0];
  endfunction

  always_comb begin
    r_ext  = IW'(r_q) <<< G;
    quad   = phi_q[W] ^ phi_q[W-1];
    x_pre  = quad ? -r_ext : r_ext;
    x_gain = (x_pre >>> 1) + (x_pre >>> 3) - (x_pre >>> 6) - (x_pre >>> 9);
    z_pre  = quad ? {~phi_q[W], phi_q[W-1:0]} : phi_q;
    x_sh   = x_q >>> i_q;
    y_sh   = y_q >>> i_q;
    at     = atan_c(i_q);
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    r_d     = r_q;
    phi_d   = phi_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = done_q;
    xo_d    = xo_q;
    yo_d    = yo_q;
    eps_d   = eps_q;
    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if (start) begin
          r_d     = r_in;
          phi_d   = phi_in;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        busy_d  = 1'b1;
        x_d     = x_gain;
        y_d     = '0;
        z_d     = z_pre;
        i_d     = 4'd0;
        state_d = S_ITER;
      end
      S_ITER: begin
        // z >= 0 rotates counter-clockwise; z wraps modulo 2^(W+1) by width.
        if (!z_q[W]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - at;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + at;
        end
        i_d = i_q + 4'd1;
        if (i_q == 4'(N - 1)) state_d = S_OUT;
      end
      default: begin
        xo_d    = sat_rnd(x_q);
        yo_d    = sat_rnd(y_q);
        eps_d   = z_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      r_q     <= '0;
      phi_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
      eps_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      r_q     <= r_d;
      phi_q   <= phi_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      eps_q   <= eps_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign x         = xo_q;
  assign y         = yo_q;
  assign eps       = eps_q;
  assign dbg_state = state_q;

endmodule
